// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-match monitor: FSM encodings and the
// all-ones constant used for saturation limits and the "no gap seen" marker.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        BAD  = 2'd3
    } state_t;

    // Wide enough for any counter width; users slice off the low CNT_W bits.
    localparam int MAX_CNT_W = 64;
    localparam logic [MAX_CNT_W-1:0] ALL_ONES = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = ALL_ONES[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_match_monitor.sv
// Counts detector matches in fixed windows, tracks the total and the smallest
// inter-match gap, and raises a sticky alarm when a window reaches THRESH.
module seq_match_monitor
    import seq_det_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_CYCLES = 1000,
    parameter int THRESH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             det,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic             win_valid,
    output logic [CNT_W-1:0] min_gap,
    output logic             alarm,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] MAX      = ALL_ONES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    state_t           state, stateNext;
    logic             active, complete, havePrev;
    logic [CNT_W-1:0] winCur, cycCnt, gapCnt;
    logic [CNT_W-1:0] winLoad, gapPlus;

    assign active   = ((state == ARM) || (state == RUN)) && en;
    assign complete = (state == RUN) && en && (cycCnt == WIN_LAST);
    assign state_o  = state;

    // Window total including a match on the closing cycle itself.
    assign winLoad = (det && (winCur != MAX)) ? winCur + CNT_W'(1) : winCur;
    // The gap register holds cycles elapsed since the last match minus one.
    assign gapPlus = (gapCnt != MAX) ? gapCnt + CNT_W'(1) : gapCnt;

    sat_counter #(.W(CNT_W)) u_total (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (active && det),
        .q   (total_cnt)
    );

    sat_counter #(.W(CNT_W)) u_window (
        .clk (clk),
        .rst (rst),
        .clr (clr || complete || !active),
        .inc (active && det),
        .q   (winCur)
    );

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk (clk),
        .rst (rst),
        .clr (clr || complete || !active),
        .inc (active && ((state == RUN) || det)),
        .q   (cycCnt)
    );

    sat_counter #(.W(CNT_W)) u_gap (
        .clk (clk),
        .rst (rst),
        .clr (clr || (active && det)),
        .inc (active),
        .q   (gapCnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (clr) begin
            stateNext = en ? ARM : IDLE;
        end else begin
            case (state)
                IDLE:    stateNext = en ? ARM : IDLE;
                ARM:     stateNext = !en ? IDLE : (det ? RUN : ARM);
                RUN:     stateNext = en ? RUN : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Window report, alarm and gap statistics; clr overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            win_valid <= 1'b0;
            alarm     <= 1'b0;
            min_gap   <= MAX;
            havePrev  <= 1'b0;
        end else if (clr) begin
            win_cnt   <= '0;
            win_valid <= 1'b0;
            alarm     <= 1'b0;
            min_gap   <= MAX;
            havePrev  <= 1'b0;
        end else begin
            win_valid <= complete;
            if (complete) begin
                win_cnt <= winLoad;
                if (winLoad >= THRESH_V) begin
                    alarm <= 1'b1;
                end
            end
            if (active && det) begin
                havePrev <= 1'b1;
                if (havePrev && (gapPlus < min_gap)) begin
                    min_gap <= gapPlus;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: a 16-bit and a 4-bit instance share
// stimulus; expected window reports are queued and matched on win_valid.
module tb_seq_match_monitor;
    import seq_det_pkg::*;

    logic clk, rst, en, clr, det;

    logic [15:0] totalA, winCntA, minGapA;
    logic        winValidA, alarmA;
    logic [1:0]  stateA;
    logic [3:0]  totalB, winCntB, minGapB;
    logic        winValidB, alarmB;
    logic [1:0]  stateB;

    int vectors    = 0;
    int miscompares = 0;
    int expA[$];
    int expB[$];

    seq_match_monitor #(.CNT_W(16), .WIN_CYCLES(10), .THRESH(3)) dutA (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .det(det),
        .total_cnt(totalA), .win_cnt(winCntA), .win_valid(winValidA),
        .min_gap(minGapA), .alarm(alarmA), .state_o(stateA)
    );

    seq_match_monitor #(.CNT_W(4), .WIN_CYCLES(10), .THRESH(3)) dutB (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .det(det),
        .total_cnt(totalB), .win_cnt(winCntB), .win_valid(winValidB),
        .min_gap(minGapB), .alarm(alarmB), .state_o(stateB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; returns just after the next rising edge.
    task automatic applyStimulus(input logic e, input logic c, input logic d);
        @(negedge clk);
        en  = e;
        clr = c;
        det = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idleTicks(input int n, input logic e);
        for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && winValidA) begin
            if (expA.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL winA_unexpected: observed strobe win_cnt=%0d expected no strobe", winCntA);
            end else begin
                checkOutput("winA_cnt", 32'(winCntA), 32'(expA.pop_front()));
            end
        end
        if (!rst && winValidB) begin
            if (expB.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL winB_unexpected: observed strobe win_cnt=%0d expected no strobe", winCntB);
            end else begin
                checkOutput("winB_cnt", 32'(winCntB), 32'(expB.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        det = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_state", 32'(stateA), 32'd0);
        checkOutput("rst_total", 32'(totalA), 32'd0);
        checkOutput("rst_win", 32'(winCntA), 32'd0);
        checkOutput("rst_valid", 32'(winValidA), 32'd0);
        checkOutput("rst_mingap", 32'(minGapA), 32'hFFFF);
        checkOutput("rst_mingapB", 32'(minGapB), 32'hF);
        checkOutput("rst_alarm", 32'(alarmA), 32'd0);

        $display("[TB] dets at 5,8,9 after ARM, then two windows");
        expA.push_back(3); expB.push_back(3);
        expA.push_back(0); expB.push_back(0);
        applyStimulus(1, 0, 0);
        checkOutput("arm_state", 32'(stateA), 32'd1);
        idleTicks(4, 1'b1);
        checkOutput("arm_hold", 32'(stateA), 32'd1);
        applyStimulus(1, 0, 1);
        checkOutput("first_total", 32'(totalA), 32'd1);
        checkOutput("first_state", 32'(stateA), 32'd2);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        checkOutput("gap3_mingap", 32'(minGapA), 32'd3);
        applyStimulus(1, 0, 1);
        checkOutput("r30_total", 32'(totalA), 32'd3);
        checkOutput("r30_mingap", 32'(minGapA), 32'd1);
        checkOutput("r30_state", 32'(stateA), 32'd2);
        checkOutput("r30_alarm_pre", 32'(alarmA), 32'd0);
        idleTicks(18, 1'b1);
        checkOutput("r31_queueA", 32'(expA.size()), 32'd0);
        checkOutput("r31_queueB", 32'(expB.size()), 32'd0);
        checkOutput("r31_alarm", 32'(alarmA), 32'd1);
        checkOutput("r31_win0", 32'(winCntA), 32'd0);
        checkOutput("r31_total", 32'(totalA), 32'd3);

        $display("[TB] clr then 20 consecutive dets");
        applyStimulus(1, 1, 0);
        checkOutput("clr_total", 32'(totalA), 32'd0);
        checkOutput("clr_alarm", 32'(alarmA), 32'd0);
        checkOutput("clr_mingap", 32'(minGapA), 32'hFFFF);
        checkOutput("clr_state", 32'(stateA), 32'd1);
        expA.push_back(10); expB.push_back(10);
        expA.push_back(10); expB.push_back(10);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1);
        checkOutput("sat_totalA", 32'(totalA), 32'd20);
        checkOutput("sat_totalB", 32'(totalB), 32'd15);
        checkOutput("b2b_mingap", 32'(minGapA), 32'd1);
        checkOutput("b2b_mingapB", 32'(minGapB), 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("sat_queueA", 32'(expA.size()), 32'd0);
        checkOutput("sat_queueB", 32'(expB.size()), 32'd0);
        checkOutput("sat_alarmB", 32'(alarmB), 32'd1);

        $display("[TB] en dropped after two dets");
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("endrop_state", 32'(stateA), 32'd0);
        checkOutput("endrop_total", 32'(totalA), 32'd2);
        checkOutput("endrop_mingap", 32'(minGapA), 32'd2);
        applyStimulus(0, 0, 1);
        idleTicks(15, 1'b0);
        checkOutput("endrop_hold", 32'(totalA), 32'd2);
        checkOutput("endrop_idle", 32'(stateA), 32'd0);
        checkOutput("endrop_queue", 32'(expA.size()), 32'd0);

        $display("[TB] clr colliding with det and window end");
        applyStimulus(1, 1, 0);
        expA.push_back(3); expB.push_back(3);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        idleTicks(7, 1'b1);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        idleTicks(7, 1'b1);
        checkOutput("pre_clr_win", 32'(winCntA), 32'd3);
        checkOutput("pre_clr_alarm", 32'(alarmA), 32'd1);
        checkOutput("pre_clr_total", 32'(totalA), 32'd5);
        applyStimulus(1, 1, 1);
        checkOutput("r33_total", 32'(totalA), 32'd0);
        checkOutput("r33_win", 32'(winCntA), 32'd0);
        checkOutput("r33_valid", 32'(winValidA), 32'd0);
        checkOutput("r33_alarm", 32'(alarmA), 32'd0);
        checkOutput("r33_mingap", 32'(minGapA), 32'hFFFF);
        checkOutput("r33_state", 32'(stateA), 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("r33_novalid", 32'(winValidA), 32'd0);
        checkOutput("r33_queue", 32'(expA.size()), 32'd0);

        $display("[TB] rst mid-window");
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        checkOutput("prerst_total", 32'(totalA), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_state", 32'(stateA), 32'd0);
        checkOutput("midrst_total", 32'(totalA), 32'd0);
        checkOutput("midrst_mingap", 32'(minGapA), 32'hFFFF);
        checkOutput("midrst_valid", 32'(winValidA), 32'd0);
        @(negedge clk);
        en  = 1'b0;
        det = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idleTicks(12, 1'b0);
        checkOutput("postrst_state", 32'(stateA), 32'd0);
        checkOutput("postrst_win", 32'(winCntA), 32'd0);
        checkOutput("postrst_queueA", 32'(expA.size()), 32'd0);
        checkOutput("postrst_queueB", 32'(expB.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_match_monitor.md
SEQ_MATCH_MONITOR -- requirements
Module: seq_match_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all counters and registers.
REQ-002 SHALL have parameter WIN_CYCLES, default 1000, observation window length in clk cycles (2..2^CNT_W-1).
REQ-003 SHALL have parameter THRESH, default 8, per-window match count that raises alarm.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  monitoring enable, level.
REQ-007 SHALL have port clr  input  1  synchronous clear of counters, alarm and stats, one-cycle pulse.
REQ-008 SHALL have port det  input  1  match pulse from the sequence-detector stage, sampled each cycle.
REQ-009 SHALL have port total_cnt  output  CNT_W  saturating count of all matches since reset/clr.
REQ-010 SHALL have port win_cnt  output  CNT_W  match count of last completed window.
REQ-011 SHALL have port win_valid  output  1  one-cycle strobe when win_cnt updates.
REQ-012 SHALL have port min_gap  output  CNT_W  smallest cycle distance between consecutive matches, all-ones if fewer than two matches.
REQ-013 SHALL have port alarm  output  1  sticky flag, set when a window count reaches THRESH.
REQ-014 SHALL have port state_o  output  2  current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states IDLE=0, ARM=1, RUN=2; code 3 unused and SHALL recover to IDLE.
REQ-016 IDLE: en=1 -> ARM next cycle; det ignored, no counter changes.
REQ-017 ARM: first det=1 -> RUN; that det SHALL be counted in total_cnt and the window; window cycle counter starts at 1 on that cycle.
REQ-018 RUN: each det=1 cycle increments total_cnt and current window count by 1; both saturate at 2^CNT_W-1, no wrap.
REQ-019 RUN: window cycle counter increments every cycle; on the cycle it equals WIN_CYCLES, win_cnt <= current count including any det that cycle, win_valid=1 next cycle, window counters restart at 0 with no cycle lost.
REQ-020 alarm SHALL set in the same cycle win_cnt is loaded with a value >= THRESH; cleared only by clr or rst.
REQ-021 gap counter SHALL count cycles since the last det in ARM/RUN; on det with a prior match, min_gap <= min(min_gap, gap); gap then restarts at 1; gap saturates.
REQ-022 en=0 in ARM or RUN -> IDLE next cycle; the partial window SHALL be discarded, not reported; total_cnt, min_gap and alarm held.
REQ-023 clr SHALL take priority over det and window completion in the same cycle: total_cnt, win_cnt, window counters, gap tracking cleared, min_gap all-ones, alarm 0, win_valid 0, FSM -> ARM if en=1 else IDLE.
REQ-024 All outputs SHALL be registered; latency det -> total_cnt update is exactly 1 cycle.
REQ-025 Back-to-back det on consecutive cycles SHALL each be counted and give gap 1.

Reset
REQ-026 On rst: FSM IDLE, total_cnt 0, win_cnt 0, win_valid 0, min_gap all-ones, alarm 0, internal counters 0.
REQ-027 rst asserted mid-window SHALL abandon the window with no win_valid strobe.

Structure
REQ-028 State encodings and the all-ones/saturation constant SHALL live in shared package seq_det_pkg.
REQ-029 A sub-module sat_counter (increment, clear, saturate, width parameter) SHALL be instantiated for total, window, cycle and gap counters.

Verification
REQ-030 en=1, det at cycles 5,8,9 after ARM -> total_cnt 3, min_gap 1, state RUN.
REQ-031 WIN_CYCLES=10, THRESH=3, 3 dets in first window -> win_cnt 3, single win_valid pulse, alarm 1 and stays 1 through an empty next window (win_cnt 0).
REQ-032 CNT_W=4, 20 consecutive dets -> total_cnt 15, no wrap.
REQ-033 clr on same cycle as det and window end -> all counters 0, alarm 0, no win_valid, min_gap 0xFFFF.
REQ-034 en dropped mid-window after 2 dets -> IDLE, no win_valid, total_cnt stays 2; rst mid-window -> all outputs at reset values immediately.
